set_ram_access_scheduler: RTL and testbench

- Front-end controller for the per-set dual-port block RAM used by the cache tag/metadata arrays.
- After reset, sweeps every set to zero.
- Afterwards, shares the RAM read port between two read requesters with round-robin arbitration and issues single-writer updates with eviction capture.
- Compensates for the RAM gating writes with its read enable and returning pre-write data on a same-cycle read/write address collision.

---
 rtl/set_ram_access_scheduler_pkg.sv | 15 +
 rtl/set_ram_access_scheduler_rr_arbiter_2.sv | 45 ++++
 rtl/set_ram_access_scheduler.sv | 136 +++++++++++++
 tb/tb_set_ram_access_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/set_ram_access_scheduler_pkg.sv
// Shared types and widths for the set RAM access scheduler and its RAM wrapper.
package set_ram_access_scheduler_pkg;

    localparam int ELEM_W    = 10;
    localparam int NUM_SETS  = 64;
    localparam int SET_PTR_W = 6;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

    typedef logic req_idx_t;

endpackage

// File: rtl/set_ram_access_scheduler_rr_arbiter_2.sv
// Two-requester round-robin arbiter; the pointer only advances when both requesters contend.
module set_ram_access_scheduler_rr_arbiter_2
    import set_ram_access_scheduler_pkg::*;
(
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       enable_in,
    input  logic [1:0] req_in,
    output logic [1:0] grant_out,
    output req_idx_t   grant_idx_out
);

    req_idx_t ptr_q;
    req_idx_t ptr_d;

    always_comb begin
        grant_out     = 2'b00;
        grant_idx_out = 1'b0;
        ptr_d         = ptr_q;
        if (enable_in) begin
            case (req_in)
                2'b01: grant_out = 2'b01;
                2'b10: begin
                    grant_out     = 2'b10;
                    grant_idx_out = 1'b1;
                end
                2'b11: begin
                    grant_out     = ptr_q ? 2'b10 : 2'b01;
                    grant_idx_out = ptr_q;
                    ptr_d         = ~ptr_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/set_ram_access_scheduler.sv
// Front end for the per-set dual-port RAM: zero sweep after reset, then arbitrated reads and writes.
// Optional SET_RAM_BYPASS_EN forwards same-cycle write data to a colliding read response.
module set_ram_access_scheduler
    import set_ram_access_scheduler_pkg::*;
#(
    parameter int SINGLE_ELEMENT_SIZE_IN_BITS = ELEM_W,
    parameter int NUMBER_SETS                 = NUM_SETS,
    parameter int SET_PTR_WIDTH_IN_BITS       = SET_PTR_W
) (
    input  logic                                   clk_in,
    input  logic                                   reset_in,
    output logic                                   init_done_out,
    input  logic                                   rd0_valid_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       rd0_set_addr_in,
    output logic                                   rd0_ready_out,
    output logic                                   rd0_resp_valid_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] rd0_resp_element_out,
    input  logic                                   rd1_valid_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       rd1_set_addr_in,
    output logic                                   rd1_ready_out,
    output logic                                   rd1_resp_valid_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] rd1_resp_element_out,
    input  logic                                   wr_valid_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       wr_set_addr_in,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] wr_element_in,
    output logic                                   wr_ready_out,
    output logic                                   evict_valid_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] evict_element_out,
    output logic                                   ram_read_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]       ram_read_set_addr_out,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_read_element_in,
    output logic                                   ram_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]       ram_write_set_addr_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_write_element_out,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_evict_element_in
);

    localparam int EW = SINGLE_ELEMENT_SIZE_IN_BITS;
    localparam int PW = SET_PTR_WIDTH_IN_BITS;
    localparam logic [PW-1:0] LAST_SET = PW'(NUMBER_SETS - 1);

    sched_state_e  state_q;
    logic [PW-1:0] init_cnt_q;
    logic [PW-1:0] rd_addr_q;
    logic [1:0]    resp_valid_q;
    logic          evict_valid_q;

    logic          run;
    logic [1:0]    grant;
    req_idx_t      grant_idx;
    logic          any_grant;
    logic [PW-1:0] grant_addr;
    logic [EW-1:0] resp_element;

    assign run = (state_q == ST_RUN);

    set_ram_access_scheduler_rr_arbiter_2 u_arb (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .enable_in     (run),
        .req_in        ({rd1_valid_in, rd0_valid_in}),
        .grant_out     (grant),
        .grant_idx_out (grant_idx)
    );

    assign any_grant  = |grant;
    assign grant_addr = grant_idx ? rd1_set_addr_in : rd0_set_addr_in;

    assign init_done_out = run;
    assign rd0_ready_out = grant[0];
    assign rd1_ready_out = grant[1];
    assign wr_ready_out  = run;

    // The RAM ignores write_en unless read_en is also high, so a lone write still asserts read_en.
    assign ram_read_en_out        = run ? (any_grant | wr_valid_in) : 1'b1;
    assign ram_read_set_addr_out  = any_grant ? grant_addr : rd_addr_q;
    assign ram_write_en_out       = run ? wr_valid_in : 1'b1;
    assign ram_write_set_addr_out = run ? wr_set_addr_in : init_cnt_q;
    assign ram_write_element_out  = run ? wr_element_in : '0;

    assign rd0_resp_valid_out   = resp_valid_q[0];
    assign rd1_resp_valid_out   = resp_valid_q[1];
    assign rd0_resp_element_out = resp_element;
    assign rd1_resp_element_out = resp_element;
    assign evict_valid_out      = evict_valid_q;
    assign evict_element_out    = ram_evict_element_in;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q       <= ST_INIT;
            init_cnt_q    <= '0;
            rd_addr_q     <= '0;
            resp_valid_q  <= '0;
            evict_valid_q <= 1'b0;
        end else begin
            resp_valid_q  <= grant;
            evict_valid_q <= run & wr_valid_in;
            if (any_grant) begin
                rd_addr_q <= grant_addr;
            end
            case (state_q)
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == LAST_SET) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN:  ;
                default: state_q <= ST_INIT;
            endcase
        end
    end

`ifdef SET_RAM_BYPASS_EN
    logic          bypass_hit_q;
    logic [EW-1:0] bypass_data_q;

    // The RAM returns pre-write data on a same-cycle collision; substitute the new element.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            bypass_hit_q  <= 1'b0;
            bypass_data_q <= '0;
        end else begin
            bypass_hit_q <= any_grant & wr_valid_in & (grant_addr == wr_set_addr_in);
            if (any_grant & wr_valid_in & (grant_addr == wr_set_addr_in)) begin
                bypass_data_q <= wr_element_in;
            end
        end
    end

    assign resp_element = bypass_hit_q ? bypass_data_q : ram_read_element_in;
`else
    assign resp_element = ram_read_element_in;
`endif

endmodule

// File: tb/tb_set_ram_access_scheduler.sv
// Directed bench for set_ram_access_scheduler with a behavioural read-enable-gated dual-port RAM.
module tb_set_ram_access_scheduler;

    logic       clk = 1'b0;
    logic       reset_in;
    logic       init_done_out;
    logic       rd0_valid_in, rd1_valid_in, wr_valid_in;
    logic [5:0] rd0_set_addr_in, rd1_set_addr_in, wr_set_addr_in;
    logic [9:0] wr_element_in;
    logic       rd0_ready_out, rd1_ready_out, wr_ready_out;
    logic       rd0_resp_valid_out, rd1_resp_valid_out, evict_valid_out;
    logic [9:0] rd0_resp_element_out, rd1_resp_element_out, evict_element_out;
    logic       ram_read_en_out, ram_write_en_out;
    logic [5:0] ram_read_set_addr_out, ram_write_set_addr_out;
    logic [9:0] ram_read_element_in, ram_write_element_out, ram_evict_element_in;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    set_ram_access_scheduler dut (
        .clk_in                 (clk),
        .reset_in               (reset_in),
        .init_done_out          (init_done_out),
        .rd0_valid_in           (rd0_valid_in),
        .rd0_set_addr_in        (rd0_set_addr_in),
        .rd0_ready_out          (rd0_ready_out),
        .rd0_resp_valid_out     (rd0_resp_valid_out),
        .rd0_resp_element_out   (rd0_resp_element_out),
        .rd1_valid_in           (rd1_valid_in),
        .rd1_set_addr_in        (rd1_set_addr_in),
        .rd1_ready_out          (rd1_ready_out),
        .rd1_resp_valid_out     (rd1_resp_valid_out),
        .rd1_resp_element_out   (rd1_resp_element_out),
        .wr_valid_in            (wr_valid_in),
        .wr_set_addr_in         (wr_set_addr_in),
        .wr_element_in          (wr_element_in),
        .wr_ready_out           (wr_ready_out),
        .evict_valid_out        (evict_valid_out),
        .evict_element_out      (evict_element_out),
        .ram_read_en_out        (ram_read_en_out),
        .ram_read_set_addr_out  (ram_read_set_addr_out),
        .ram_read_element_in    (ram_read_element_in),
        .ram_write_en_out       (ram_write_en_out),
        .ram_write_set_addr_out (ram_write_set_addr_out),
        .ram_write_element_out  (ram_write_element_out),
        .ram_evict_element_in   (ram_evict_element_in)
    );

    // RAM model: registered read, writes gated by read_en, pre-write data on collision.
    logic [9:0] mem [64];
    always @(posedge clk) begin
        if (ram_read_en_out) begin
            ram_read_element_in <= mem[ram_read_set_addr_out];
            if (ram_write_en_out) begin
                ram_evict_element_in        <= mem[ram_write_set_addr_out];
                mem[ram_write_set_addr_out] <= ram_write_element_out;
            end
        end
    end

    typedef struct {
        logic       r0v;
        logic [5:0] r0a;
        logic       r1v;
        logic [5:0] r1a;
        logic       wv;
        logic [5:0] wa;
        logic [9:0] wd;
        logic [1:0] rdy;
        logic [9:0] rdata;
        logic [9:0] edata;
    } vec_t;

    function automatic vec_t mk(logic r0v, logic [5:0] r0a, logic r1v, logic [5:0] r1a,
                                logic wv, logic [5:0] wa, logic [9:0] wd,
                                logic [1:0] rdy, logic [9:0] rdata, logic [9:0] edata);
        vec_t v;
        v.r0v = r0v; v.r0a = r0a; v.r1v = r1v; v.r1a = r1a;
        v.wv = wv; v.wa = wa; v.wd = wd; v.rdy = rdy; v.rdata = rdata; v.edata = edata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        rd0_valid_in = 1'b0; rd0_set_addr_in = '0;
        rd1_valid_in = 1'b0; rd1_set_addr_in = '0;
        wr_valid_in  = 1'b0; wr_set_addr_in  = '0; wr_element_in = '0;
    endtask

    // Called right after reset release at a falling edge; checks the full zero sweep.
    task automatic check_init_sweep();
        rd0_valid_in = 1'b1; rd1_valid_in = 1'b1; wr_valid_in = 1'b1;
        wr_set_addr_in = 6'd33; wr_element_in = 10'h3FF;
        for (int i = 0; i < 64; i++) begin
            #1;
            check("init_wr_en", 32'(ram_write_en_out), 32'd1);
            check("init_rd_en", 32'(ram_read_en_out), 32'd1);
            check("init_wr_addr", 32'(ram_write_set_addr_out), 32'(i));
            check("init_wr_data", 32'(ram_write_element_out), 32'd0);
            check("init_ready", 32'({rd1_ready_out, rd0_ready_out, wr_ready_out}), 32'd0);
            check("init_done_low", 32'(init_done_out), 32'd0);
            @(negedge clk);
            check("init_no_evict", 32'(evict_valid_out), 32'd0);
        end
        #1;
        check("init_done_high", 32'(init_done_out), 32'd1);
        check("run_wr_ready", 32'(wr_ready_out), 32'd1);
        $display("[TB] init sweep of 64 sets checked");
        drive_idle();
    endtask

    vec_t vecs [13];
    logic [9:0] collide_exp;

    initial begin
`ifdef SET_RAM_BYPASS_EN
        collide_exp = 10'h3FF;
`else
        collide_exp = 10'h011;
`endif
        //          r0v r0a   r1v r1a   wv wa    wd       rdy    rdata    edata
        vecs[0]  = mk(0, 6'd0, 0, 6'd0, 1, 6'd5, 10'h2AA, 2'b00, 10'h000, 10'h000);
        vecs[1]  = mk(1, 6'd5, 0, 6'd0, 0, 6'd0, 10'h000, 2'b01, 10'h2AA, 10'h000);
        vecs[2]  = mk(1, 6'd1, 1, 6'd2, 1, 6'd2, 10'h0AB, 2'b01, 10'h000, 10'h000);
        vecs[3]  = mk(1, 6'd1, 1, 6'd2, 0, 6'd0, 10'h000, 2'b10, 10'h0AB, 10'h000);
        vecs[4]  = mk(1, 6'd1, 1, 6'd2, 0, 6'd0, 10'h000, 2'b01, 10'h000, 10'h000);
        vecs[5]  = mk(1, 6'd1, 1, 6'd2, 0, 6'd0, 10'h000, 2'b10, 10'h0AB, 10'h000);
        vecs[6]  = mk(0, 6'd0, 0, 6'd0, 1, 6'd9, 10'h155, 2'b00, 10'h000, 10'h000);
        vecs[7]  = mk(0, 6'd0, 0, 6'd0, 1, 6'd9, 10'h0F0, 2'b00, 10'h000, 10'h155);
        vecs[8]  = mk(0, 6'd0, 0, 6'd0, 1, 6'd7, 10'h011, 2'b00, 10'h000, 10'h000);
        vecs[9]  = mk(1, 6'd7, 0, 6'd0, 1, 6'd7, 10'h3FF, 2'b01, collide_exp, 10'h011);
        vecs[10] = mk(0, 6'd0, 1, 6'd7, 0, 6'd0, 10'h000, 2'b10, 10'h3FF, 10'h000);
        vecs[11] = mk(0, 6'd0, 0, 6'd0, 0, 6'd0, 10'h000, 2'b00, 10'h000, 10'h000);
        vecs[12] = mk(0, 6'd0, 1, 6'd9, 0, 6'd0, 10'h000, 2'b10, 10'h0F0, 10'h000);

        drive_idle();
        reset_in = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_init_done", 32'(init_done_out), 32'd0);
        check("rst_resp_valid", 32'({rd1_resp_valid_out, rd0_resp_valid_out}), 32'd0);
        check("rst_evict_valid", 32'(evict_valid_out), 32'd0);
        @(negedge clk);
        reset_in = 1'b1;
        check_init_sweep();

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rd0_valid_in = vecs[i].r0v; rd0_set_addr_in = vecs[i].r0a;
            rd1_valid_in = vecs[i].r1v; rd1_set_addr_in = vecs[i].r1a;
            wr_valid_in  = vecs[i].wv;  wr_set_addr_in  = vecs[i].wa;
            wr_element_in = vecs[i].wd;
            #1;
            check("ready", 32'({rd1_ready_out, rd0_ready_out}), 32'(vecs[i].rdy));
            check("ram_rd_en", 32'(ram_read_en_out), 32'((|vecs[i].rdy) | vecs[i].wv));
            check("ram_wr_en", 32'(ram_write_en_out), 32'(vecs[i].wv));
            @(posedge clk);
            #1;
            check("resp_valid", 32'({rd1_resp_valid_out, rd0_resp_valid_out}), 32'(vecs[i].rdy));
            if (vecs[i].rdy[0]) check("rd0_data", 32'(rd0_resp_element_out), 32'(vecs[i].rdata));
            if (vecs[i].rdy[1]) check("rd1_data", 32'(rd1_resp_element_out), 32'(vecs[i].rdata));
            check("evict_valid", 32'(evict_valid_out), 32'(vecs[i].wv));
            if (vecs[i].wv) check("evict_data", 32'(evict_element_out), 32'(vecs[i].edata));
            $display("[TB] vec %0d rdy=%b resp0=%b/%h resp1=%b/%h evict=%b/%h", i,
                     {rd1_ready_out, rd0_ready_out}, rd0_resp_valid_out, rd0_resp_element_out,
                     rd1_resp_valid_out, rd1_resp_element_out, evict_valid_out, evict_element_out);
        end

        // Reset while a read response and an eviction are in flight.
        @(negedge clk);
        rd0_valid_in = 1'b1; rd0_set_addr_in = 6'd9;
        wr_valid_in = 1'b1; wr_set_addr_in = 6'd3; wr_element_in = 10'h001;
        @(posedge clk);
        #1;
        check("mid_resp_pre", 32'(rd0_resp_valid_out), 32'd1);
        check("mid_data_pre", 32'(rd0_resp_element_out), 32'h0F0);
        check("mid_evict_pre", 32'(evict_valid_out), 32'd1);
        reset_in = 1'b0;
        #1;
        check("mid_resp_drop", 32'(rd0_resp_valid_out), 32'd0);
        check("mid_evict_drop", 32'(evict_valid_out), 32'd0);
        check("mid_init_done", 32'(init_done_out), 32'd0);
        check("mid_wr_addr", 32'(ram_write_set_addr_out), 32'd0);
        $display("[TB] reset asserted with response in flight");
        drive_idle();
        @(negedge clk);
        reset_in = 1'b1;
        check_init_sweep();

        // Set 9 was swept back to zero.
        @(negedge clk);
        rd0_valid_in = 1'b1; rd0_set_addr_in = 6'd9;
        @(posedge clk);
        #1;
        check("post_reinit_valid", 32'(rd0_resp_valid_out), 32'd1);
        check("post_reinit_data", 32'(rd0_resp_element_out), 32'd0);
        $display("[TB] post-reinit read set 9 -> %h", rd0_resp_element_out);
        drive_idle();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
